// File: rtl/uart_load_ctrl.sv
// Host packet parser sitting behind uart_rx: turns framed load packets into byte writes
// on a req/ack memory port and drives the console hold line.
module uart_load_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_error,
  output logic        o_wr_req,
  output logic [23:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_ack,
  output logic        o_core_hold,
  output logic        o_pkt_ok,
  output logic        o_pkt_err,
  output logic [2:0]  o_err_code,
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] SYNC        = 8'hAA;
  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_HOLD    = 8'h02;
  localparam logic [7:0] CMD_RELEASE = 8'h03;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_CMD     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_FRAME   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_A0, S_A1, S_A2, S_L0, S_L1, S_DATA, S_WAIT, S_CSUM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic [7:0]    r_cmd;
  logic [23:0]   r_addr;
  logic [15:0]   r_len;
  logic [7:0]    r_csum;
  logic          r_wr_req;
  logic [23:0]   r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_core_hold;
  logic          r_pkt_ok;
  logic          r_pkt_err;
  logic [2:0]    r_err_code;
  logic [2:0]    r_pend_err;
  logic [TW-1:0] r_tcnt;

  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_head;
  logic        w_pop;
  logic        w_push;
  logic        w_overflow;
  logic        w_ack;
  logic [15:0] w_len_full;
  logic        w_start;
  logic        w_bad_cmd;
  logic        w_issue;
  logic        w_csum_good;
  logic        w_csum_bad;
  logic        w_counting;
  logic        w_timeout;
  logic        w_frame;
  logic [2:0]  w_err_now;
  logic [2:0]  w_abort_err;
  logic        w_abort;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_push     = i_rx_valid && (!w_full || w_pop);
  assign w_overflow = i_rx_valid && w_full && !w_pop;
  assign w_ack      = r_wr_req && i_wr_ack;
  assign w_len_full = {w_head, r_len[7:0]};

  // Idle-line watchdog only runs while we are actually starved for bytes mid-packet.
  assign w_counting = !i_rx_valid && (r_state != S_IDLE) && (r_state != S_WAIT) && w_empty;
  assign w_timeout  = w_counting && (r_tcnt == TLAST);
  assign w_frame    = i_rx_error && (r_state != S_IDLE);

  always_comb begin
    w_err_now = ERR_NONE;
    if (w_bad_cmd)       w_err_now = ERR_CMD;
    else if (w_timeout)  w_err_now = ERR_TIMEOUT;
    else if (w_overflow) w_err_now = ERR_OVF;
    else if (w_frame)    w_err_now = ERR_FRAME;
  end

  // A stalled write must finish its handshake, so errors seen in WAIT are parked until the ack.
  assign w_abort_err = (r_pend_err != ERR_NONE) ? r_pend_err : w_err_now;
  assign w_abort     = (w_abort_err != ERR_NONE) && ((r_state != S_WAIT) || w_ack);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_abort ? S_IDLE : w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_bad_cmd   = 1'b0;
    w_issue     = 1'b0;
    w_csum_good = 1'b0;
    w_csum_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head == SYNC) begin
            w_start = 1'b1;
            w_next  = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head inside {CMD_WRITE, CMD_HOLD, CMD_RELEASE}) w_next = S_A0;
          else                                                  w_bad_cmd = 1'b1;
        end
      end
      S_A0: if (!w_empty) begin w_pop = 1'b1; w_next = S_A1; end
      S_A1: if (!w_empty) begin w_pop = 1'b1; w_next = S_A2; end
      S_A2: if (!w_empty) begin w_pop = 1'b1; w_next = S_L0; end
      S_L0: if (!w_empty) begin w_pop = 1'b1; w_next = S_L1; end
      S_L1: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if ((r_cmd != CMD_WRITE) && (w_len_full != 16'd0)) w_bad_cmd = 1'b1;
          else if (w_len_full == 16'd0)                      w_next = S_CSUM;
          else                                               w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_issue = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ack) w_next = (r_len == 16'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_IDLE;
          if (w_head == r_csum) w_csum_good = 1'b1;
          else                  w_csum_bad  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_tcnt <= '0;
    end else if (w_counting && !w_abort) begin
      r_tcnt <= r_tcnt + TW'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cmd       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_csum      <= '0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_core_hold <= 1'b0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_pend_err  <= ERR_NONE;
    end else begin
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
      if (w_abort) begin
        r_pkt_err  <= 1'b1;
        r_err_code <= w_abort_err;
        r_pend_err <= ERR_NONE;
        r_wr_req   <= 1'b0;
      end else begin
        if (w_abort_err != ERR_NONE) r_pend_err <= w_abort_err;
        if (w_start) begin
          r_err_code <= ERR_NONE;
          r_csum     <= '0;
        end
        if (w_pop) begin
          case (r_state)
            S_CMD:  begin r_cmd <= w_head;          r_csum <= r_csum + w_head; end
            S_A0:   begin r_addr[7:0]   <= w_head;  r_csum <= r_csum + w_head; end
            S_A1:   begin r_addr[15:8]  <= w_head;  r_csum <= r_csum + w_head; end
            S_A2:   begin r_addr[23:16] <= w_head;  r_csum <= r_csum + w_head; end
            S_L0:   begin r_len[7:0]    <= w_head;  r_csum <= r_csum + w_head; end
            S_L1:   begin r_len[15:8]   <= w_head;  r_csum <= r_csum + w_head; end
            S_DATA: r_csum <= r_csum + w_head;
            default: ;
          endcase
        end
        if (w_issue) begin
          r_wr_req  <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= w_head;
        end
        if (w_ack) begin
          r_wr_req <= 1'b0;
          r_addr   <= r_addr + 24'd1;
          r_len    <= r_len - 16'd1;
        end
        // Hold/release only take effect once the whole packet has verified.
        if (w_csum_good) begin
          r_pkt_ok <= 1'b1;
          if (r_cmd == CMD_HOLD)    r_core_hold <= 1'b1;
          if (r_cmd == CMD_RELEASE) r_core_hold <= 1'b0;
        end
        if (w_csum_bad) begin
          r_pkt_err  <= 1'b1;
          r_err_code <= ERR_CSUM;
        end
      end
    end
  end

  assign o_wr_req    = r_wr_req;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_core_hold = r_core_hold;
  assign o_pkt_ok    = r_pkt_ok;
  assign o_pkt_err   = r_pkt_err;
  assign o_err_code  = r_err_code;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Bench for uart_load_ctrl: table of whole packets with hand-computed results,
// followed by overflow, timeout, framing-error and reset-mid-write sequences.
module tb_uart_load_ctrl;

   localparam int TimeoutClks = 300;
   localparam int ByteGap     = 5;

   typedef struct {
      string              name;
      int                 nBytes;
      logic [0:11][7:0]   bytes;
      int                 ackDelay;
      int                 expWrites;
      logic [0:1][23:0]   expAddr;
      logic [0:1][7:0]    expData;
      int                 expOk;
      int                 expErr;
      logic [2:0]         expCode;
      logic               expHold;
   } VecT;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        rxValid = 1'b0;
   logic        rxError = 1'b0;
   logic        wrReq;
   logic [23:0] wrAddr;
   logic [7:0]  wrData;
   logic        wrAck = 1'b0;
   logic        coreHold;
   logic        pktOk;
   logic        pktErr;
   logic [2:0]  errCode;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int okSeen = 0;
   int errSeen = 0;
   int ackWait = 0;
   int ackDelay = 1;
   logic ackHold = 1'b0;
   logic [23:0] logAddr[$];
   logic [7:0]  logData[$];
   VecT vecs[10];

   uart_load_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CLKS(TimeoutClks)) dut (
      .i_clk(clock),
      .i_resetn(resetN),
      .i_rx_data(rxData),
      .i_rx_valid(rxValid),
      .i_rx_error(rxError),
      .o_wr_req(wrReq),
      .o_wr_addr(wrAddr),
      .o_wr_data(wrData),
      .i_wr_ack(wrAck),
      .o_core_hold(coreHold),
      .o_pkt_ok(pktOk),
      .o_pkt_err(pktErr),
      .o_err_code(errCode),
      .o_busy(busy)
   );

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   // Memory-port model and pulse monitor: counts status pulses, and acks each write
   // request after ackDelay idle cycles, logging the address/data it accepted.
   always @(negedge clock) begin
      if (pktOk) okSeen++;
      if (pktErr) errSeen++;
      if (wrAck) begin
         wrAck = 1'b0;
         ackWait = 0;
      end else if (wrReq && !ackHold) begin
         if (ackWait >= ackDelay) begin
            wrAck = 1'b1;
            ackWait = 0;
            logAddr.push_back(wrAddr);
            logData.push_back(wrData);
         end else begin
            ackWait++;
         end
      end else begin
         ackWait = 0;
      end
   end

   // Safety net so a stuck design can never hang the run.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got still running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(negedge clock);
      rxData = b;
      rxValid = 1'b1;
      @(negedge clock);
      rxValid = 1'b0;
      repeat (ByteGap) @(negedge clock);
   endtask

   task automatic pulseRxError();
      @(negedge clock);
      rxError = 1'b1;
      @(negedge clock);
      rxError = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int maxCycles);
      int n;
      n = 0;
      while (busy && n < maxCycles) begin
         @(negedge clock);
         n++;
      end
      checkOutput({name, ".idle"}, {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clock);
   endtask

   task automatic applyStimulus(input VecT v);
      int okBase;
      int errBase;
      int logBase;
      okBase = okSeen;
      errBase = errSeen;
      logBase = logAddr.size();
      ackDelay = v.ackDelay;
      for (int i = 0; i < v.nBytes; i++) sendByte(v.bytes[i]);
      waitIdle(v.name, 300);
      checkOutput({v.name, ".writes"}, logAddr.size() - logBase, v.expWrites);
      for (int w = 0; w < v.expWrites; w++) begin
         if (logAddr.size() > logBase + w) begin
            checkOutput($sformatf("%s.addr%0d", v.name, w), {8'd0, logAddr[logBase + w]}, {8'd0, v.expAddr[w]});
            checkOutput($sformatf("%s.data%0d", v.name, w), {24'd0, logData[logBase + w]}, {24'd0, v.expData[w]});
         end
      end
      checkOutput({v.name, ".pktOk"}, okSeen - okBase, v.expOk);
      checkOutput({v.name, ".pktErr"}, errSeen - errBase, v.expErr);
      checkOutput({v.name, ".errCode"}, {29'd0, errCode}, {29'd0, v.expCode});
      checkOutput({v.name, ".coreHold"}, {31'd0, coreHold}, {31'd0, v.expHold});
   endtask

   // Main sequence: reset, packet table, then the multi-cycle corner cases.
   initial begin
      int okBase;
      int errBase;
      int logBase;
      int n;

      vecs[0] = '{"writeGood", 10, {8'hAA,8'h01,8'h00,8'h10,8'h00,8'h02,8'h00,8'h11,8'h22,8'h46,{2{8'h00}}},
                  1, 2, {24'h001000,24'h001001}, {8'h11,8'h22}, 1, 0, 3'd0, 1'b0};
      vecs[1] = '{"writeBadCsum", 10, {8'hAA,8'h01,8'h00,8'h10,8'h00,8'h02,8'h00,8'h11,8'h22,8'h34,{2{8'h00}}},
                  1, 2, {24'h001000,24'h001001}, {8'h11,8'h22}, 0, 1, 3'd1, 1'b0};
      vecs[2] = '{"holdSet", 8, {8'hAA,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h02,{4{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 1, 0, 3'd0, 1'b1};
      vecs[3] = '{"holdBadCsum", 8, {8'hAA,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05,{4{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 0, 1, 3'd1, 1'b1};
      vecs[4] = '{"holdRelease", 8, {8'hAA,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00,8'h03,{4{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 1, 0, 3'd0, 1'b0};
      vecs[5] = '{"badCmd", 2, {8'hAA,8'h07,{10{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 0, 1, 3'd2, 1'b0};
      vecs[6] = '{"holdLenNonZero", 7, {8'hAA,8'h02,8'h00,8'h00,8'h00,8'h01,8'h00,{5{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 0, 1, 3'd2, 1'b0};
      vecs[7] = '{"resyncGarbage", 10, {8'h55,8'h13,8'hAA,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00,8'h03,{2{8'h00}}},
                  1, 0, {24'h0,24'h0}, {8'h0,8'h0}, 1, 0, 3'd0, 1'b0};
      vecs[8] = '{"csumWrapAck0", 9, {8'hAA,8'h01,8'hFF,8'hFF,8'h00,8'h01,8'h00,8'hFF,8'hFF,{3{8'h00}}},
                  0, 1, {24'h00FFFF,24'h0}, {8'hFF,8'h0}, 1, 0, 3'd0, 1'b0};
      vecs[9] = '{"addrWrap", 10, {8'hAA,8'h01,8'hFF,8'hFF,8'hFF,8'h02,8'h00,8'hD0,8'hD1,8'hA1,{2{8'h00}}},
                  3, 2, {24'hFFFFFF,24'h000000}, {8'hD0,8'hD1}, 1, 0, 3'd0, 1'b0};

      repeat (4) @(negedge clock);
      checkOutput("reset.wrReq", {31'd0, wrReq}, 32'd0);
      checkOutput("reset.busy", {31'd0, busy}, 32'd0);
      checkOutput("reset.errCode", {29'd0, errCode}, 32'd0);
      checkOutput("reset.coreHold", {31'd0, coreHold}, 32'd0);
      checkOutput("reset.pulses", {30'd0, pktOk, pktErr}, 32'd0);
      checkOutput("reset.wrAddr", {8'd0, wrAddr}, 32'd0);
      resetN = 1'b1;
      repeat (2) @(negedge clock);

      for (int v = 0; v < 10; v++) applyStimulus(vecs[v]);

      // Overflow while the write port stalls for ~2000 clocks; error lands only after the ack.
      okBase = okSeen;
      errBase = errSeen;
      logBase = logAddr.size();
      ackHold = 1'b1;
      ackDelay = 1;
      sendByte(8'hAA); sendByte(8'h01); sendByte(8'h00); sendByte(8'h20); sendByte(8'h00);
      sendByte(8'h06); sendByte(8'h00);
      for (int i = 0; i < 6; i++) sendByte(8'h11 + 8'(i));
      sendByte(8'h00);
      repeat (1900) @(negedge clock);
      checkOutput("ovf.wrReqHeld", {31'd0, wrReq}, 32'd1);
      checkOutput("ovf.busyHeld", {31'd0, busy}, 32'd1);
      checkOutput("ovf.noErrBeforeAck", errSeen - errBase, 32'd0);
      ackHold = 1'b0;
      waitIdle("ovf", 100);
      checkOutput("ovf.errCode", {29'd0, errCode}, 32'd4);
      checkOutput("ovf.pktErr", errSeen - errBase, 32'd1);
      checkOutput("ovf.pktOk", okSeen - okBase, 32'd0);
      checkOutput("ovf.writes", logAddr.size() - logBase, 32'd1);
      if (logAddr.size() > logBase) begin
         checkOutput("ovf.addr0", {8'd0, logAddr[logBase]}, 32'h002000);
         checkOutput("ovf.data0", {24'd0, logData[logBase]}, 32'h11);
      end
      applyStimulus(vecs[0]);

      // Inter-byte timeout: silence after the command byte.
      errBase = errSeen;
      sendByte(8'hAA);
      sendByte(8'h01);
      repeat (200) @(negedge clock);
      checkOutput("timeout.notYet", errSeen - errBase, 32'd0);
      checkOutput("timeout.busyBefore", {31'd0, busy}, 32'd1);
      waitIdle("timeout", 400);
      checkOutput("timeout.pktErr", errSeen - errBase, 32'd1);
      checkOutput("timeout.errCode", {29'd0, errCode}, 32'd3);

      // Framing error mid-packet aborts; the same error while idle is ignored.
      errBase = errSeen;
      sendByte(8'hAA);
      sendByte(8'h01);
      sendByte(8'h00);
      pulseRxError();
      waitIdle("frame", 50);
      checkOutput("frame.pktErr", errSeen - errBase, 32'd1);
      checkOutput("frame.errCode", {29'd0, errCode}, 32'd5);
      errBase = errSeen;
      pulseRxError();
      repeat (3) @(negedge clock);
      checkOutput("frameIdle.noPktErr", errSeen - errBase, 32'd0);
      checkOutput("frameIdle.errCode", {29'd0, errCode}, 32'd5);
      checkOutput("frameIdle.busy", {31'd0, busy}, 32'd0);

      // Reset while a write request is outstanding, with core_hold set beforehand.
      applyStimulus(vecs[2]);
      ackHold = 1'b1;
      sendByte(8'hAA); sendByte(8'h01); sendByte(8'h00); sendByte(8'h30);
      sendByte(8'h00); sendByte(8'h01); sendByte(8'h00); sendByte(8'h77);
      n = 0;
      while (!wrReq && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("rst.wrReqRaised", {31'd0, wrReq}, 32'd1);
      resetN = 1'b0;
      @(negedge clock);
      checkOutput("rst.wrReq", {31'd0, wrReq}, 32'd0);
      checkOutput("rst.wrAddr", {8'd0, wrAddr}, 32'd0);
      checkOutput("rst.wrData", {24'd0, wrData}, 32'd0);
      checkOutput("rst.coreHold", {31'd0, coreHold}, 32'd0);
      checkOutput("rst.busy", {31'd0, busy}, 32'd0);
      checkOutput("rst.errCode", {29'd0, errCode}, 32'd0);
      checkOutput("rst.pulses", {30'd0, pktOk, pktErr}, 32'd0);
      resetN = 1'b1;
      ackHold = 1'b0;
      repeat (2) @(negedge clock);
      applyStimulus(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
